// File: rtl/sam_mem_pkg.sv
// sam_mem_pkg: shared state/owner types and constants for the main-RAM arbiter.
package sam_mem_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_DMA, OWN_FDD, OWN_CPU} arb_owner_t;

    localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;

    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (&v) ? v : v + 6'd1;
    endfunction

endpackage

// File: rtl/sam_arb_prio.sv
// sam_arb_prio: combinational grant select, dma > fdd > cpu, with optional CPU-over-FDD override.
module sam_arb_prio
    import sam_mem_pkg::*;
(
    input  logic       dma_req_i,
    input  logic       fdd_req_i,
    input  logic       cpu_req_i,
    input  logic       guard_hit_i,
    output arb_owner_t grant_o
);

    // guard_hit_i only matters when the CPU is actually waiting
    assign grant_o = dma_req_i                                  ? OWN_DMA :
                     (fdd_req_i && !(guard_hit_i && cpu_req_i)) ? OWN_FDD :
                     cpu_req_i                                  ? OWN_CPU : OWN_NONE;

endmodule

// File: rtl/sam_mem_arbiter.sv
// sam_mem_arbiter: shares the main-RAM port between loader DMA, FDD buffer and Z80, one access in flight.
// Define SAM_MEMARB_GUARD_EN to let a waiting CPU overtake FDD after GUARD_MAX consecutive FDD grants.
module sam_mem_arbiter
    import sam_mem_pkg::*;
#(
    parameter int AW        = 25,
    parameter int TIMEOUT   = 63,
    parameter int GUARD_MAX = 4
)(
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          dma_req_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [7:0]    dma_din_i,
    output logic          dma_ack_o,
    input  logic          fdd_req_i,
    input  logic [AW-1:0] fdd_addr_i,
    output logic          fdd_ack_o,
    output logic [7:0]    fdd_dout_o,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [7:0]    cpu_din_i,
    output logic          cpu_ack_o,
    output logic [7:0]    cpu_dout_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_din_o,
    output logic          mem_we_o,
    output logic          mem_rd_o,
    input  logic          mem_ready_i,
    input  logic [7:0]    mem_dout_i,
    output logic          timeout_err_o
);

    localparam logic [5:0] TMO_LIM = 6'(TIMEOUT);

    arb_state_t    state_q, state_d;
    arb_owner_t    owner_q, owner_d, grant;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic [5:0]    tmo_q, tmo_d, tmo_nx;
    logic [7:0]    fdd_dout_q, fdd_dout_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;
    logic          terr_q, terr_d;
    logic          fin, forced, guard_hit;
    logic [7:0]    rdata;

    sam_arb_prio u_prio (
        .dma_req_i   (dma_req_i),
        .fdd_req_i   (fdd_req_i),
        .cpu_req_i   (cpu_req_i),
        .guard_hit_i (guard_hit),
        .grant_o     (grant)
    );

`ifdef SAM_MEMARB_GUARD_EN
    localparam int GW = $clog2(GUARD_MAX + 1);

    logic [GW-1:0] guard_q, guard_d;

    // counts FDD wins that left the CPU waiting; any CPU win restarts the count
    always_comb begin
        guard_d = guard_q;
        if (state_q == ARB_IDLE)
            guard_d = (grant == OWN_CPU)                ? '0 :
                      (grant == OWN_FDD && cpu_req_i)   ? guard_q + GW'(1) : guard_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) guard_q <= '0;
        else       guard_q <= guard_d;
    end

    assign guard_hit = (guard_q == GW'(GUARD_MAX));
`else
    logic unused_guard;
    assign unused_guard = |GUARD_MAX;
    assign guard_hit    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        din_d      = din_q;
        tmo_d      = tmo_q;
        fdd_dout_d = fdd_dout_q;
        cpu_dout_d = cpu_dout_q;
        fin        = 1'b0;
        forced     = 1'b0;
        tmo_nx     = sat_inc6(tmo_q);
        case (state_q)
            ARB_IDLE: if (grant != OWN_NONE) begin
                state_d = ARB_ISSUE;
                owner_d = grant;
                tmo_d   = '0;
                we_d    = (grant == OWN_DMA) || (grant == OWN_CPU && cpu_we_i);
                addr_d  = (grant == OWN_DMA) ? dma_addr_i : (grant == OWN_FDD) ? fdd_addr_i : cpu_addr_i;
                din_d   = (grant == OWN_DMA) ? dma_din_i : (grant == OWN_CPU) ? cpu_din_i : 8'h00;
            end
            ARB_ISSUE: begin
                fin     = mem_ready_i;
                state_d = mem_ready_i ? ARB_DONE : ARB_WAIT;
            end
            ARB_WAIT: begin
                tmo_d   = tmo_nx;
                fin     = mem_ready_i;
                forced  = !mem_ready_i && (tmo_nx == TMO_LIM);
                state_d = (fin || forced) ? ARB_DONE : ARB_WAIT;
            end
            default: state_d = ARB_IDLE;
        endcase
        rdata = forced ? RD_TIMEOUT_DATA : mem_dout_i;
        if ((fin || forced) && !we_q) begin
            fdd_dout_d = (owner_q == OWN_FDD) ? rdata : fdd_dout_q;
            cpu_dout_d = (owner_q == OWN_CPU) ? rdata : cpu_dout_q;
        end
        terr_d = terr_q | forced;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_NONE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            tmo_q      <= '0;
            fdd_dout_q <= '0;
            cpu_dout_q <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            tmo_q      <= tmo_d;
            fdd_dout_q <= fdd_dout_d;
            cpu_dout_q <= cpu_dout_d;
            terr_q     <= terr_d;
        end
    end

    assign dma_ack_o     = (state_q == ARB_DONE) && (owner_q == OWN_DMA);
    assign fdd_ack_o     = (state_q == ARB_DONE) && (owner_q == OWN_FDD);
    assign cpu_ack_o     = (state_q == ARB_DONE) && (owner_q == OWN_CPU);
    assign mem_we_o      = (state_q == ARB_ISSUE) && we_q;
    assign mem_rd_o      = (state_q == ARB_ISSUE) && !we_q;
    assign mem_addr_o    = addr_q;
    assign mem_din_o     = din_q;
    assign fdd_dout_o    = fdd_dout_q;
    assign cpu_dout_o    = cpu_dout_q;
    assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_sam_mem_arbiter.sv
// tb_sam_mem_arbiter: directed and randomized checks of sam_mem_arbiter against a simple sram model
// and a transaction-level reference memory.
module tb_sam_mem_arbiter;

    localparam int AW        = 25;
    localparam int TIMEOUT   = 63;
    localparam int GUARD_MAX = 4;
`ifdef SAM_MEMARB_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          dma_req, fdd_req, cpu_req, cpu_we;
    logic [AW-1:0] dma_addr, fdd_addr, cpu_addr;
    logic [7:0]    dma_din, cpu_din;
    logic          dma_ack_o, fdd_ack_o, cpu_ack_o;
    logic [7:0]    fdd_dout_o, cpu_dout_o;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_din_o;
    logic          mem_we_o, mem_rd_o;
    logic          mem_ready_i;
    logic [7:0]    mem_dout_i;
    logic          timeout_err_o;

    always #5 clk_sys = ~clk_sys;

    sam_mem_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT), .GUARD_MAX(GUARD_MAX)) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .dma_req_i     (dma_req),
        .dma_addr_i    (dma_addr),
        .dma_din_i     (dma_din),
        .dma_ack_o     (dma_ack_o),
        .fdd_req_i     (fdd_req),
        .fdd_addr_i    (fdd_addr),
        .fdd_ack_o     (fdd_ack_o),
        .fdd_dout_o    (fdd_dout_o),
        .cpu_req_i     (cpu_req),
        .cpu_we_i      (cpu_we),
        .cpu_addr_i    (cpu_addr),
        .cpu_din_i     (cpu_din),
        .cpu_ack_o     (cpu_ack_o),
        .cpu_dout_o    (cpu_dout_o),
        .mem_addr_o    (mem_addr_o),
        .mem_din_o     (mem_din_o),
        .mem_we_o      (mem_we_o),
        .mem_rd_o      (mem_rd_o),
        .mem_ready_i   (mem_ready_i),
        .mem_dout_i    (mem_dout_i),
        .timeout_err_o (timeout_err_o)
    );

    // sram model: lat_cfg<0 never answers, 0 answers in the strobe cycle, N answers N cycles later
    logic [7:0] sram [256];
    int         lat_cfg = 1;
    int         cnt;
    logic       inj_rdy = 1'b0;
    logic       fill = 1'b0;
    logic       pre_we = 1'b0;
    logic [7:0] pre_a, pre_d;

    function automatic logic [7:0] pat(input int a);
        return 8'(a) ^ 8'h3C;
    endfunction

    always @(posedge clk_sys) begin
        if (reset) cnt <= 0;
        else if ((mem_rd_o || mem_we_o) && lat_cfg > 0) cnt <= lat_cfg;
        else if (cnt > 0) cnt <= cnt - 1;
        if (fill) for (int i = 0; i < 256; i++) sram[i] <= pat(i);
        else if (pre_we) sram[pre_a] <= pre_d;
        if (mem_we_o) sram[mem_addr_o[7:0]] <= mem_din_o;
    end

    assign mem_ready_i = inj_rdy || (cnt == 1) || (lat_cfg == 0 && (mem_rd_o || mem_we_o));
    assign mem_dout_i  = sram[mem_addr_o[7:0]];

    int            n_chk = 0, n_err = 0;
    int            idx, nrd, nwe, nother;
    logic [AW-1:0] io_addr;
    logic [7:0]    io_din;
    logic [7:0]    ref_mem [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drop_all;
        dma_req = 1'b0;
        fdd_req = 1'b0;
        cpu_req = 1'b0;
    endtask

    // one request from client who (0 dma, 1 fdd, 2 cpu); idx = samples from request to ack
    task automatic run_one(input int who, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        logic mine;
        idx = -1; nrd = 0; nwe = 0; nother = 0;
        case (who)
            0: begin dma_req = 1'b1; dma_addr = a; dma_din = d; end
            1: begin fdd_req = 1'b1; fdd_addr = a; end
            default: begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d; end
        endcase
        for (int i = 1; i <= 120 && idx < 0; i++) begin
            tick;
            if (mem_rd_o || mem_we_o) begin io_addr = mem_addr_o; io_din = mem_din_o; end
            nrd += int'(mem_rd_o);
            nwe += int'(mem_we_o);
            mine = (who == 0) ? dma_ack_o : (who == 1) ? fdd_ack_o : cpu_ack_o;
            nother += int'(dma_ack_o) + int'(fdd_ack_o) + int'(cpu_ack_o) - int'(mine);
            if (mine) begin idx = i; drop_all; end
        end
        drop_all;
        tick;
    endtask

    int         ord [3];
    int         nack, multi, seq_n, got;
    int         seq [12];
    logic       saw;
    logic [2:0] acks;
    logic       act [3];
    logic       rwe [3];
    logic [AW-1:0] raddr [3];
    logic [7:0] rdin [3];
    logic [7:0] obs_d;

    initial begin
        reset = 1'b1;
        drop_all;
        cpu_we = 1'b0;
        dma_addr = '0; fdd_addr = '0; cpu_addr = '0; dma_din = '0; cpu_din = '0;
        pre_a = '0; pre_d = '0;
        io_addr = '0; io_din = '0;
        fill = 1'b1;
        tick;
        fill = 1'b0;
        tick; tick;
        chk("rst_acks", 32'({dma_ack_o, fdd_ack_o, cpu_ack_o}), 32'd0);
        chk("rst_strobes", 32'({mem_we_o, mem_rd_o}), 32'd0);
        chk("rst_terr", 32'(timeout_err_o), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_mem_din", 32'(mem_din_o), 32'd0);
        chk("rst_fdd_dout", 32'(fdd_dout_o), 32'd0);
        chk("rst_cpu_dout", 32'(cpu_dout_o), 32'd0);
        reset = 1'b0;
        pre_a = 8'h45; pre_d = 8'hA5; pre_we = 1'b1;
        tick;
        pre_we = 1'b0;

        // CPU read with 2-cycle sram latency
        lat_cfg = 2;
        run_one(2, 1'b0, 25'h0012345, 8'h00);
        chk("t1_ack_idx", 32'(idx), 32'd4);
        chk("t1_rd_pulses", 32'(nrd), 32'd1);
        chk("t1_we_pulses", 32'(nwe), 32'd0);
        chk("t1_other_acks", 32'(nother), 32'd0);
        chk("t1_addr", 32'(io_addr), 32'h0012345);
        chk("t1_cpu_dout", 32'(cpu_dout_o), 32'hA5);

        // three simultaneous requests: DMA writes the byte FDD then reads
        lat_cfg = 1;
        dma_addr = 25'h1000010; dma_din = 8'hC3;
        fdd_addr = 25'h0000010;
        cpu_addr = 25'h0000020; cpu_we = 1'b0;
        dma_req = 1'b1; fdd_req = 1'b1; cpu_req = 1'b1;
        ord = '{-1, -1, -1};
        nack = 0; multi = 0;
        for (int i = 0; i < 60 && nack < 3; i++) begin
            tick;
            if (int'(dma_ack_o) + int'(fdd_ack_o) + int'(cpu_ack_o) > 1) multi++;
            if (dma_ack_o) begin ord[nack] = 0; nack++; dma_req = 1'b0; end
            else if (fdd_ack_o) begin ord[nack] = 1; nack++; fdd_req = 1'b0; end
            else if (cpu_ack_o) begin ord[nack] = 2; nack++; cpu_req = 1'b0; end
        end
        drop_all;
        tick;
        chk("t2_nack", 32'(nack), 32'd3);
        chk("t2_first_dma", 32'(ord[0]), 32'd0);
        chk("t2_second_fdd", 32'(ord[1]), 32'd1);
        chk("t2_third_cpu", 32'(ord[2]), 32'd2);
        chk("t2_multi_ack", 32'(multi), 32'd0);
        chk("t2_fdd_dout", 32'(fdd_dout_o), 32'hC3);
        chk("t2_cpu_dout", 32'(cpu_dout_o), 32'(pat(8'h20)));

        // sram never answers an FDD read
        lat_cfg = -1;
        run_one(1, 1'b0, 25'h01ABCDE, 8'h00);
        chk("t3_ack_seen", 32'(idx > 0), 32'd1);
        chk("t3_ack_not_early", 32'(idx >= TIMEOUT), 32'd1);
        chk("t3_ack_not_late", 32'(idx <= TIMEOUT + 4), 32'd1);
        chk("t3_fdd_dout", 32'(fdd_dout_o), 32'hFF);
        chk("t3_terr", 32'(timeout_err_o), 32'd1);
        lat_cfg = 1;
        run_one(2, 1'b0, 25'h0000010, 8'h00);
        chk("t3_cpu_dout_after", 32'(cpu_dout_o), 32'hC3);
        chk("t3_terr_sticky", 32'(timeout_err_o), 32'd1);

        // reset while a CPU write waits for the sram
        lat_cfg = -1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h0000099; cpu_din = 8'h11;
        nwe = 0; saw = 1'b0;
        repeat (4) begin tick; nwe += int'(mem_we_o); saw |= cpu_ack_o; end
        reset = 1'b1; cpu_req = 1'b0;
        tick;
        saw |= cpu_ack_o;
        reset = 1'b0;
        nrd = 0;
        inj_rdy = 1'b1;
        tick;
        inj_rdy = 1'b0;
        saw |= cpu_ack_o;
        repeat (4) begin tick; saw |= cpu_ack_o; nrd += int'(mem_rd_o) + int'(mem_we_o); end
        chk("t4_we_pulse", 32'(nwe), 32'd1);
        chk("t4_no_ack", 32'(saw), 32'd0);
        chk("t4_no_strobe_after", 32'(nrd), 32'd0);
        chk("t4_terr_cleared", 32'(timeout_err_o), 32'd0);
        chk("t4_cpu_dout_reset", 32'(cpu_dout_o), 32'd0);

        // clean read after the abort, then a zero-wait write
        lat_cfg = 1;
        run_one(2, 1'b0, 25'h0000077, 8'h00);
        chk("t5_idle_latency", 32'(idx), 32'd3);
        chk("t5_read_dout", 32'(cpu_dout_o), 32'(pat(8'h77)));
        lat_cfg = 0;
        run_one(2, 1'b1, 25'h0000055, 8'h5A);
        chk("t5_zw_ack_idx", 32'(idx), 32'd2);
        chk("t5_zw_we_pulses", 32'(nwe), 32'd1);
        chk("t5_zw_rd_pulses", 32'(nrd), 32'd0);
        chk("t5_zw_din", 32'(io_din), 32'h5A);
        chk("t5_zw_dout_kept", 32'(cpu_dout_o), 32'(pat(8'h77)));
        chk("t5_zw_sram", 32'(sram[8'h55]), 32'h5A);

        // FDD and CPU both held continuously
        lat_cfg = 1;
        fdd_addr = 25'h30; cpu_addr = 25'h31; cpu_we = 1'b0;
        fdd_req = 1'b1; cpu_req = 1'b1;
        seq_n = 0;
        for (int i = 0; i < 200 && seq_n < 12; i++) begin
            tick;
            if (fdd_ack_o) begin seq[seq_n] = 1; seq_n++; end
            else if (cpu_ack_o) begin seq[seq_n] = 2; seq_n++; end
        end
        fdd_req = 1'b0;
        chk("t6_nack", 32'(seq_n), 32'd12);
        for (int k = 0; k < seq_n; k++)
            chk($sformatf("t6_grant_%0d", k), 32'(seq[k]), (GUARD && k % (GUARD_MAX + 1) == GUARD_MAX) ? 32'd2 : 32'd1);
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            tick;
            if (cpu_ack_o) got = 1;
        end
        drop_all;
        tick;
        chk("t6_cpu_after_fdd_drop", 32'(got), 32'd1);

        // random traffic against a transaction-level reference memory
        fill = 1'b1;
        tick;
        fill = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        for (int c = 0; c < 3; c++) begin act[c] = 1'b0; rwe[c] = 1'b0; raddr[c] = '0; rdin[c] = '0; end
        nack = 0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            lat_cfg = $urandom_range(0, 3);
            tick;
            acks = {cpu_ack_o, fdd_ack_o, dma_ack_o};
            if (acks != 3'b000) chk("rnd_one_ack", 32'($countones(acks)), 32'd1);
            for (int c = 0; c < 3; c++) begin
                if (acks[c]) begin
                    chk($sformatf("rnd_ack_active_%0d", c), 32'(act[c]), 32'd1);
                    obs_d = (c == 1) ? fdd_dout_o : cpu_dout_o;
                    if (!rwe[c]) chk($sformatf("rnd_rdata_%0d", c), 32'(obs_d), 32'(ref_mem[raddr[c][7:0]]));
                    else ref_mem[raddr[c][7:0]] = rdin[c];
                    act[c] = 1'b0;
                    nack++;
                end
            end
            if (cyc < 800) begin
                for (int c = 0; c < 3; c++) begin
                    if (!act[c] && $urandom_range(0, 7) == 0) begin
                        act[c]   = 1'b1;
                        rwe[c]   = (c == 0) ? 1'b1 : (c == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                        raddr[c] = AW'($urandom);
                        rdin[c]  = 8'($urandom);
                    end
                end
            end
            dma_req = act[0]; dma_addr = raddr[0]; dma_din = rdin[0];
            fdd_req = act[1]; fdd_addr = raddr[1];
            cpu_req = act[2]; cpu_we = rwe[2]; cpu_addr = raddr[2]; cpu_din = rdin[2];
            if (cyc >= 800 && !act[0] && !act[1] && !act[2]) break;
        end
        drop_all;
        chk("rnd_drained", 32'({act[0], act[1], act[2]}), 32'd0);
        chk("rnd_enough_traffic", 32'(nack >= 20), 32'd1);
        chk("rnd_no_timeout", 32'(timeout_err_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
